// File: rtl/bram_readback_pkg.sv
// bram_readback_pkg
//   Shared definitions for the BRAM read-back checker and the block-RAM fill
//   logic that uses the same Fibonacci pattern.
//   - state_t : read-back sequencer state encoding (2 bits)
//   - DEF_*   : default widths / latency used as parameter defaults
//   - FIB_SEED_A / FIB_SEED_B : first two words of the pattern (F0, F1)
package bram_readback_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_RD_LAT = 1;
    localparam int DEF_ERR_W  = 8;

    localparam int FIB_SEED_A = 0;
    localparam int FIB_SEED_B = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bram_readback_fib_pair_gen.sv
// fib_pair_gen
//   Holds the expected Fibonacci word pair (ea, eb) = (F2k, F2k+1) and steps
//   it forward by two terms per advance, so a consumer can check two
//   consecutive words per cycle.
//   Ports:
//     clk_i   in  : rising-edge clock
//     rst_i   in  : asynchronous active-high reset (pair returns to seeds)
//     load_i  in  : reload the seeds (F0, F1); has priority over adv_i
//     adv_i   in  : step (ea, eb) -> (ea+eb, ea+2*eb), truncated to DATA_W
//     ea_o    out : expected even-offset word
//     eb_o    out : expected odd-offset word
module fib_pair_gen
    import bram_readback_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              adv_i,
    output logic [DATA_W-1:0] ea_o,
    output logic [DATA_W-1:0] eb_o
);

    logic [DATA_W-1:0] ea_q, eb_q;
    logic [DATA_W-1:0] ea_d, eb_d;

    always_comb begin
        ea_d = ea_q;
        eb_d = eb_q;
        if (load_i) begin
            ea_d = DATA_W'(FIB_SEED_A);
            eb_d = DATA_W'(FIB_SEED_B);
        end else if (adv_i) begin
            // F(n+2) = F(n)+F(n+1); F(n+3) = F(n+1)+F(n+2) = F(n)+2*F(n+1)
            ea_d = ea_q + eb_q;
            eb_d = ea_q + (eb_q << 1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ea_q <= DATA_W'(FIB_SEED_A);
            eb_q <= DATA_W'(FIB_SEED_B);
        end else begin
            ea_q <= ea_d;
            eb_q <= eb_d;
        end
    end

    assign ea_o = ea_q;
    assign eb_o = eb_q;

endmodule

// File: rtl/bram_readback.sv
// bram_readback
//   Read-only sweep of a dual-port BRAM: two consecutive words per cycle
//   (even offsets on port A, odd on port B), streamed out with their address
//   and checked against the Fibonacci sequence mod 2^DATA_W. Reports a
//   saturating mismatch count and the first failing address.
//   Ports:
//     clk, reset              : clock, asynchronous active-high reset
//     start, base_addr, length: sweep request (sampled in IDLE only)
//     q_a, q_b                : BRAM read data
//     addr_a, addr_b, we_a/b  : BRAM address / write enables (writes never)
//     busy, done              : sweep in progress / one-cycle completion
//     rd_valid_a/b, rd_addr,
//     rd_data_a/b             : returned word stream (port B word at rd_addr+1)
//     err_cnt, err_valid,
//     err_addr                : mismatch statistics of the current/last sweep
module bram_readback
    import bram_readback_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] q_a,
    input  logic [DATA_W-1:0] q_b,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              we_a,
    output logic              we_b,
    output logic              busy,
    output logic              done,
    output logic              rd_valid_a,
    output logic              rd_valid_b,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr
);

    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [ERR_W:0] sum;
        sum = {1'b0, cnt} + (ERR_W+1)'(inc);
        if (sum[ERR_W]) begin
            return '1;
        end
        return sum[ERR_W-1:0];
    endfunction

    state_t state_q, state_d;

    logic [ADDR_W:0]   rem_q;
    logic [ADDR_W-1:0] addr_a_q, addr_b_q;
    logic              busy_q, done_q;

    logic [RD_LAT-1:0] vsh_a_q, vsh_b_q;
    logic [ADDR_W-1:0] ash_q [RD_LAT];

    logic              rd_valid_a_q, rd_valid_b_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] rd_data_a_q, rd_data_b_q;

    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_valid_q, err_valid_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic              start_ok;
    logic              issue_a, issue_b;
    logic [DATA_W-1:0] exp_a, exp_b;
    logic              mis_a, mis_b;

    // A start seen during the done pulse (state already IDLE) still belongs
    // to a busy block and is dropped.
    assign start_ok = (state_q == ST_IDLE) && start && !done_q;
    assign issue_a  = (state_q == ST_ISSUE);
    // With an odd count the last pair carries only the port-A word.
    assign issue_b  = issue_a && (rem_q >= (ADDR_W+1)'(2));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = (length == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (rem_q <= (ADDR_W+1)'(2)) state_d = ST_DRAIN;
            // Once nothing is left in the latency pipe, the last pair is in
            // the rd_data register; its error update lands with DONE.
            ST_DRAIN: if (vsh_a_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    fib_pair_gen #(
        .DATA_W(DATA_W)
    ) u_fib (
        .clk_i (clk),
        .rst_i (reset),
        .load_i(start_ok),
        .adv_i (rd_valid_a_q),
        .ea_o  (exp_a),
        .eb_o  (exp_b)
    );

    assign mis_a = rd_valid_a_q && (rd_data_a_q != exp_a);
    assign mis_b = rd_valid_b_q && (rd_data_b_q != exp_b);

    always_comb begin
        err_cnt_d   = err_cnt_q;
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (start_ok) begin
            err_cnt_d   = '0;
            err_valid_d = 1'b0;
            err_addr_d  = '0;
        end else if (mis_a || mis_b) begin
            err_cnt_d = sat_add(err_cnt_q, {1'b0, mis_a} + {1'b0, mis_b});
            if (!err_valid_q) begin
                err_valid_d = 1'b1;
                // Port A holds the lower address, so it wins a double miss.
                err_addr_d  = mis_a ? rd_addr_q : rd_addr_q + ADDR_W'(1);
            end
        end
    end

    // Issue stage: FSM, address counter, remaining-word counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE) || (state_q == ST_DONE);
            done_q  <= (state_q == ST_DONE);
            if (start_ok) begin
                rem_q    <= length;
                addr_a_q <= base_addr;
                addr_b_q <= base_addr + ADDR_W'(1);
            end else if (issue_a) begin
                rem_q    <= issue_b ? rem_q - (ADDR_W+1)'(2) : rem_q - (ADDR_W+1)'(1);
                addr_a_q <= addr_a_q + ADDR_W'(2);
                addr_b_q <= addr_b_q + ADDR_W'(2);
            end
        end
    end

    // BRAM latency stages: valid bits and port-A address ride with the read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsh_a_q <= '0;
            vsh_b_q <= '0;
        end else begin
            vsh_a_q[0] <= issue_a;
            vsh_b_q[0] <= issue_b;
            for (int i = 1; i < RD_LAT; i++) begin
                vsh_a_q[i] <= vsh_a_q[i-1];
                vsh_b_q[i] <= vsh_b_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        ash_q[0] <= addr_a_q;
        for (int i = 1; i < RD_LAT; i++) begin
            ash_q[i] <= ash_q[i-1];
        end
    end

    // Return stage: register BRAM data, then update error statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            rd_addr_q    <= '0;
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            err_cnt_q    <= '0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            rd_valid_a_q <= vsh_a_q[RD_LAT-1];
            rd_valid_b_q <= vsh_b_q[RD_LAT-1];
            if (vsh_a_q[RD_LAT-1]) begin
                rd_addr_q   <= ash_q[RD_LAT-1];
                rd_data_a_q <= q_a;
            end
            if (vsh_b_q[RD_LAT-1]) begin
                rd_data_b_q <= q_b;
            end
            err_cnt_q   <= err_cnt_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign addr_a     = addr_a_q;
    assign addr_b     = addr_b_q;
    assign we_a       = 1'b0;
    assign we_b       = 1'b0;
    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;
    assign rd_addr    = rd_addr_q;
    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign err_cnt    = err_cnt_q;
    assign err_valid  = err_valid_q;
    assign err_addr   = err_addr_q;

endmodule
